// File: rtl/axis_pkt_rr_arbiter.sv
// Packet-granular round-robin arbiter.
// Merges C_NUM_PORTS AXI-Stream packet sources onto one registered output stream.
// A grant is held from the first beat to tlast, so packets never interleave, and the
// starting point of the search rotates past the last served port so sources share fairly.
// A watchdog terminates a granted packet whose source stops supplying beats while the
// output could accept them: an error-flagged tlast beat goes downstream and the source
// gets a one-cycle drop pulse.
module axis_pkt_rr_arbiter #(
  parameter int  C_NUM_PORTS  = 4,
  parameter int  C_DATA_WIDTH = 8,
  parameter int  C_MTY_WIDTH  = 8,
  parameter int  C_TIMEOUT    = 255,
  localparam int C_IDX_BITS   = (C_NUM_PORTS > 1) ? $clog2(C_NUM_PORTS) : 1
) (
  input  logic                              aclk,
  input  logic                              areset,
  input  logic [C_NUM_PORTS-1:0]            s_axis_tvalid,
  input  logic [C_NUM_PORTS*C_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [C_NUM_PORTS-1:0]            s_axis_tlast,
  input  logic [C_NUM_PORTS*C_MTY_WIDTH-1:0]  s_axis_tuser_mty,
  output logic [C_NUM_PORTS-1:0]            s_axis_tready,
  output logic [C_NUM_PORTS-1:0]            drop_incmpt_pkt,
  output logic                              m_axis_tvalid,
  output logic [C_DATA_WIDTH-1:0]           m_axis_tdata,
  output logic                              m_axis_tlast,
  output logic [C_MTY_WIDTH-1:0]            m_axis_tuser_mty,
  output logic [C_IDX_BITS-1:0]             m_axis_tdest,
  output logic                              m_axis_tuser_err,
  input  logic                              m_axis_tready,
  output logic [15:0]                       abort_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_ABORT
  } state_t;

  state_t                  state_q, state_d;
  logic [C_IDX_BITS-1:0]   rr_ptr_q, rr_ptr_d;
  logic [C_IDX_BITS-1:0]   grant_idx_q, grant_idx_d;
  logic [15:0]             wd_cnt_q, wd_cnt_d;
  logic [15:0]             abort_cnt_q, abort_cnt_d;

  logic                    m_tvalid_q, m_tvalid_d;
  logic [C_DATA_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic                    m_tlast_q, m_tlast_d;
  logic [C_MTY_WIDTH-1:0]  m_tmty_q, m_tmty_d;
  logic [C_IDX_BITS-1:0]   m_tdest_q, m_tdest_d;
  logic                    m_terr_q, m_terr_d;

  // Output register can take a new beat this cycle.
  logic                    space;
  // Inputs of the granted port; no other port is ever looked at past arbitration.
  logic                    g_tvalid;
  logic                    g_tlast;
  logic [C_DATA_WIDTH-1:0] g_tdata;
  logic [C_MTY_WIDTH-1:0]  g_tmty;
  // Port after the granted one, wrapping N-1 -> 0; becomes the next search start.
  logic [C_IDX_BITS-1:0]   grant_inc;
  // Result of the round-robin search over the current requests.
  logic                    req_found;
  logic [C_IDX_BITS-1:0]   req_idx;

  assign space     = !m_tvalid_q || m_axis_tready;
  assign g_tvalid  = s_axis_tvalid[grant_idx_q];
  assign g_tlast   = s_axis_tlast[grant_idx_q];
  assign g_tdata   = s_axis_tdata[int'(grant_idx_q) * C_DATA_WIDTH +: C_DATA_WIDTH];
  assign g_tmty    = s_axis_tuser_mty[int'(grant_idx_q) * C_MTY_WIDTH +: C_MTY_WIDTH];
  assign grant_inc = (int'(grant_idx_q) == C_NUM_PORTS - 1) ? '0
                                                            : grant_idx_q + C_IDX_BITS'(1);

  // Round-robin search: first requesting port at rr_ptr, rr_ptr+1, ... modulo N.
  always_comb begin
    int                    cand;
    logic [C_IDX_BITS-1:0] cand_idx;
    req_found = 1'b0;
    req_idx   = rr_ptr_q;
    cand      = 0;
    cand_idx  = '0;
    for (int i = 0; i < C_NUM_PORTS; i++) begin
      cand = int'(rr_ptr_q) + i;
      if (cand >= C_NUM_PORTS) begin
        cand = cand - C_NUM_PORTS;
      end
      cand_idx = C_IDX_BITS'(cand);
      if (!req_found && s_axis_tvalid[cand_idx]) begin
        req_found = 1'b1;
        req_idx   = cand_idx;
      end
    end
  end

  // Next-state logic: arbitration, beat transfer, watchdog and abort handling.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can leave one
    // unassigned and infer a latch.
    state_d         = state_q;
    rr_ptr_d        = rr_ptr_q;
    grant_idx_d     = grant_idx_q;
    wd_cnt_d        = wd_cnt_q;
    abort_cnt_d     = abort_cnt_q;
    m_tvalid_d      = m_tvalid_q;
    m_tdata_d       = m_tdata_q;
    m_tlast_d       = m_tlast_q;
    m_tmty_d        = m_tmty_q;
    m_tdest_d       = m_tdest_q;
    m_terr_d        = m_terr_q;
    s_axis_tready   = '0;
    drop_incmpt_pkt = '0;

    // A drained output register goes empty unless a new beat is loaded below.
    if (space) begin
      m_tvalid_d = 1'b0;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (req_found) begin
          grant_idx_d = req_idx;
          state_d     = ST_BUSY;
        end
      end

      ST_BUSY: begin
        s_axis_tready[grant_idx_q] = space;
        if (space) begin
          if (g_tvalid) begin
            m_tvalid_d = 1'b1;
            m_tdata_d  = g_tdata;
            m_tlast_d  = g_tlast;
            m_tmty_d   = g_tmty;
            m_tdest_d  = grant_idx_q;
            m_terr_d   = 1'b0;
            wd_cnt_d   = '0;
            if (g_tlast) begin
              rr_ptr_d = grant_inc;
              state_d  = ST_IDLE;
            end
          end else begin
            // Source starved while the output could accept: count toward the abort.
            // Backpressure (space=0) leaves the count untouched.
            wd_cnt_d = wd_cnt_q + 16'd1;
            if (wd_cnt_q == 16'(C_TIMEOUT - 1)) begin
              state_d = ST_ABORT;
            end
          end
        end
      end

      ST_ABORT: begin
        if (space) begin
          m_tvalid_d                   = 1'b1;
          m_tdata_d                    = '0;
          m_tlast_d                    = 1'b1;
          m_tmty_d                     = '0;
          m_tdest_d                    = grant_idx_q;
          m_terr_d                     = 1'b1;
          drop_incmpt_pkt[grant_idx_q] = 1'b1;
          if (abort_cnt_q != 16'hFFFF) begin
            abort_cnt_d = abort_cnt_q + 16'd1;
          end
          rr_ptr_d = grant_inc;
          wd_cnt_d = '0;
          state_d  = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-high reset.
  always_ff @(posedge aclk) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (areset) begin
      state_q     <= ST_IDLE;
      rr_ptr_q    <= '0;
      grant_idx_q <= '0;
      wd_cnt_q    <= '0;
      abort_cnt_q <= '0;
      m_tvalid_q  <= 1'b0;
      m_tdata_q   <= '0;
      m_tlast_q   <= 1'b0;
      m_tmty_q    <= '0;
      m_tdest_q   <= '0;
      m_terr_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      grant_idx_q <= grant_idx_d;
      wd_cnt_q    <= wd_cnt_d;
      abort_cnt_q <= abort_cnt_d;
      m_tvalid_q  <= m_tvalid_d;
      m_tdata_q   <= m_tdata_d;
      m_tlast_q   <= m_tlast_d;
      m_tmty_q    <= m_tmty_d;
      m_tdest_q   <= m_tdest_d;
      m_terr_q    <= m_terr_d;
    end
  end

  assign m_axis_tvalid    = m_tvalid_q;
  assign m_axis_tdata     = m_tdata_q;
  assign m_axis_tlast     = m_tlast_q;
  assign m_axis_tuser_mty = m_tmty_q;
  assign m_axis_tdest     = m_tdest_q;
  assign m_axis_tuser_err = m_terr_q;
  assign abort_cnt        = abort_cnt_q;

endmodule
